// File: rtl/adder_tree_pipe.sv
// Pipelined N-input unsigned adder tree (LG register levels, full precision) with a frame accumulator.
// Optional macro ADDER_TREE_SAT_EN: accumulator clamps to all-ones on overflow instead of wrapping.
module adder_tree_pipe #(
  parameter int N_IN  = 4,
  parameter int IN_W  = 14,
  parameter int ACC_W = 24
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [N_IN*IN_W-1:0]              in_data,
  input  logic                              acc_mode,
  input  logic                              acc_clr,
  output logic                              out_valid,
  output logic [IN_W+$clog2(N_IN)-1:0]      sum,
  output logic                              acc_valid,
  output logic [ACC_W-1:0]                  acc,
  output logic                              acc_ovf
);
  localparam int LG = $clog2(N_IN);

  // Handshake: in_valid qualifies in_data for exactly one cycle; there is no backpressure,
  // so every valid set is accepted and emerges LG cycles later as out_valid, in order.
  genvar k, j;
  for (k = 1; k <= LG; k++) begin : g_lvl
    localparam int W = IN_W + k;
    localparam int M = N_IN >> k;

    logic [2*M*(W-1)-1:0] w_src;
    logic                 w_vin;
    logic [M*W-1:0]       w_nxt;
    logic [M*W-1:0]       r_d;
    logic                 r_v;

    if (k == 1) begin : g_src
      assign w_src = in_data;
      assign w_vin = in_valid;
    end else begin : g_src
      assign w_src = g_lvl[k-1].r_d;
      assign w_vin = g_lvl[k-1].r_v;
    end

    // Each pairwise add grows by one bit so the carry is never dropped.
    for (j = 0; j < M; j++) begin : g_add
      assign w_nxt[j*W +: W] = {1'b0, w_src[2*j*(W-1) +: W-1]}
                             + {1'b0, w_src[(2*j+1)*(W-1) +: W-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else begin
        r_v <= w_vin;
        if (w_vin) r_d <= w_nxt;
      end
    end
  end

  assign out_valid = g_lvl[LG].r_v;
  assign sum       = g_lvl[LG].r_d;

  logic             w_event;
  logic [ACC_W-1:0] w_sum_ext;
  logic [ACC_W:0]   w_add;
  logic [ACC_W-1:0] r_acc;
  logic             r_acc_ovf;
  logic             r_acc_valid;

  assign w_event   = out_valid & acc_mode;
  assign w_sum_ext = ACC_W'(sum);
  assign w_add     = {1'b0, r_acc} + {1'b0, w_sum_ext};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_acc_ovf   <= 1'b0;
      r_acc_valid <= 1'b0;
    end else begin
      r_acc_valid <= w_event | acc_clr;
      if (acc_clr) begin
        r_acc     <= w_event ? w_sum_ext : '0;
        r_acc_ovf <= 1'b0;
      end else if (w_event) begin
        if (w_add[ACC_W]) r_acc_ovf <= 1'b1;
`ifdef ADDER_TREE_SAT_EN
        r_acc <= w_add[ACC_W] ? '1 : w_add[ACC_W-1:0];
`else
        r_acc <= w_add[ACC_W-1:0];
`endif
      end
    end
  end

  assign acc       = r_acc;
  assign acc_ovf   = r_acc_ovf;
  assign acc_valid = r_acc_valid;
endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe: vector table plus hand sequences for accumulate, overflow, reset.
module tb_adder_tree_pipe;
`ifdef ADDER_TREE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk, rst, in_valid, acc_mode, acc_clr;
  logic [55:0] in_data;
  logic        out_valid, acc_valid, acc_ovf;
  logic [15:0] sum;
  logic [23:0] acc;
  logic        out_valid16, acc_valid16, acc_ovf16;
  logic [15:0] sum16, acc16;

  adder_tree_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .acc_mode(acc_mode), .acc_clr(acc_clr), .out_valid(out_valid), .sum(sum),
    .acc_valid(acc_valid), .acc(acc), .acc_ovf(acc_ovf)
  );

  adder_tree_pipe #(.ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .acc_mode(acc_mode), .acc_clr(acc_clr), .out_valid(out_valid16), .sum(sum16),
    .acc_valid(acc_valid16), .acc(acc16), .acc_ovf(acc_ovf16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  logic [15:0] exp_q[$];
  logic [1:0]  vline = 2'b00;
  logic [15:0] last_sum = 16'd0;
  logic [31:0] m_acc24 = 0, m_acc16 = 0;
  logic        m_ovf24 = 0, m_ovf16 = 0, m_v24 = 0, m_v16 = 0;

  typedef struct {
    logic        v;
    logic [13:0] l0, l1, l2, l3;
    logic [15:0] exp_sum;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic void acc_step(inout logic [31:0] a, inout logic o, output logic v,
                                   input logic ev, input logic clr, input logic [31:0] s,
                                   input int w);
    logic [32:0] t;
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    v = ev | clr;
    if (clr) begin
      a = ev ? s : 32'd0;
      o = 1'b0;
    end else if (ev) begin
      t = {1'b0, a} + {1'b0, s};
      if (t > {1'b0, mask}) begin
        o = 1'b1;
        a = SAT ? mask : (t[31:0] & mask);
      end else begin
        a = t[31:0];
      end
    end
  endfunction

  // driver: advance one clock, update the reference model, compare every output
  task automatic tick();
    logic ev, cur_v;
    ev    = vline[1] & acc_mode;
    cur_v = in_valid;
    acc_step(m_acc24, m_ovf24, m_v24, ev, acc_clr, {16'd0, last_sum}, 24);
    acc_step(m_acc16, m_ovf16, m_v16, ev, acc_clr, {16'd0, last_sum}, 16);
    @(posedge clk);
    #1;
    vline = {vline[0], cur_v};
    if (vline[1]) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL exp_q: out_valid expected with empty queue");
      end else begin
        last_sum = exp_q.pop_front();
      end
    end
    if (acc_valid) pulses++;
    check("out_valid", {31'd0, out_valid}, {31'd0, vline[1]});
    check("sum", {16'd0, sum}, {16'd0, last_sum});
    check("out_valid16", {31'd0, out_valid16}, {31'd0, vline[1]});
    check("sum16", {16'd0, sum16}, {16'd0, last_sum});
    check("acc", {8'd0, acc}, m_acc24);
    check("acc_ovf", {31'd0, acc_ovf}, {31'd0, m_ovf24});
    check("acc_valid", {31'd0, acc_valid}, {31'd0, m_v24});
    check("acc16", {16'd0, acc16}, m_acc16);
    check("acc_ovf16", {31'd0, acc_ovf16}, {31'd0, m_ovf16});
    check("acc_valid16", {31'd0, acc_valid16}, {31'd0, m_v16});
  endtask

  task automatic drive(input logic v, input logic [13:0] l, input logic [15:0] e);
    in_valid = v;
    in_data  = {l, l, l, l};
    if (v) exp_q.push_back(e);
    tick();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 14'd1111,  14'd1111,  14'd1111,  14'd1111,  16'd4444};
    tbl[1]  = '{1'b0, 14'd0,     14'd0,     14'd0,     14'd0,     16'd0};
    tbl[2]  = '{1'b0, 14'd0,     14'd0,     14'd0,     14'd0,     16'd0};
    tbl[3]  = '{1'b1, 14'd1111,  14'd1111,  14'd1111,  14'd1111,  16'd4444};
    tbl[4]  = '{1'b1, 14'd3333,  14'd3333,  14'd3333,  14'd3333,  16'd13332};
    tbl[5]  = '{1'b1, 14'd5555,  14'd5555,  14'd5555,  14'd5555,  16'd22220};
    tbl[6]  = '{1'b0, 14'd0,     14'd0,     14'd0,     14'd0,     16'd0};
    tbl[7]  = '{1'b0, 14'd0,     14'd0,     14'd0,     14'd0,     16'd0};
    tbl[8]  = '{1'b1, 14'd16383, 14'd16383, 14'd16383, 14'd16383, 16'd65532};
    tbl[9]  = '{1'b0, 14'd0,     14'd0,     14'd0,     14'd0,     16'd0};
    tbl[10] = '{1'b1, 14'd1,     14'd2,     14'd3,     14'd4,     16'd10};
    tbl[11] = '{1'b1, 14'd16383, 14'd0,     14'd0,     14'd1,     16'd16384};
    tbl[12] = '{1'b1, 14'd0,     14'd100,   14'd0,     14'd0,     16'd100};
    tbl[13] = '{1'b0, 14'd0,     14'd0,     14'd0,     14'd0,     16'd0};
    tbl[14] = '{1'b0, 14'd0,     14'd0,     14'd0,     14'd0,     16'd0};
    tbl[15] = '{1'b0, 14'd0,     14'd0,     14'd0,     14'd0,     16'd0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; acc_mode = 1'b0; acc_clr = 1'b0;
    #11;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_acc", {8'd0, acc}, 32'd0);
    check("rst_acc_ovf", {31'd0, acc_ovf}, 32'd0);
    check("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
    #1 rst = 1'b0;

    // table: latency, back-to-back, gaps, full-scale, lane packing
    for (int i = 0; i < 16; i++) begin
      in_valid = tbl[i].v;
      in_data  = {tbl[i].l3, tbl[i].l2, tbl[i].l1, tbl[i].l0};
      if (tbl[i].v) exp_q.push_back(tbl[i].exp_sum);
      tick();
      if (i == 0) check("lat_not_early", {31'd0, out_valid}, 32'd0);
      if (i == 1) check("lat2_sum_4444", {16'd0, sum}, 32'd4444);
      if (i == 7) check("hold_22220", {16'd0, sum}, 32'd22220);
      if (i == 10) check("full_65532", {16'd0, sum}, 32'd65532);
    end
    in_valid = 1'b0;
    check("acc_idle_zero", {8'd0, acc}, 32'd0);
    check("last_sum_100", {16'd0, sum}, 32'd100);

    // accumulate three 4444 sums, then clear-and-load with 100
    acc_mode = 1'b1;
    pulses = 0;
    drive(1'b1, 14'd1111, 16'd4444);
    drive(1'b1, 14'd1111, 16'd4444);
    drive(1'b1, 14'd1111, 16'd4444);
    for (int i = 0; i < 3; i++) drive(1'b0, 14'd0, 16'd0);
    check("acc_13332", {8'd0, acc}, 32'd13332);
    check("acc_pulses", pulses, 32'd3);
    drive(1'b1, 14'd25, 16'd100);
    drive(1'b0, 14'd0, 16'd0);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("clr_load_100", {8'd0, acc}, 32'd100);
    check("clr_load_ovf", {31'd0, acc_ovf}, 32'd0);
    check("clr_load_valid", {31'd0, acc_valid}, 32'd1);

    // clear without event, then overflow the 16-bit accumulator
    acc_mode = 1'b0;
    acc_clr  = 1'b1;
    tick();
    acc_clr  = 1'b0;
    check("clr_only_acc", {8'd0, acc}, 32'd0);
    check("clr_only_valid", {31'd0, acc_valid}, 32'd1);
    acc_mode = 1'b1;
    drive(1'b1, 14'd16383, 16'd65532);
    drive(1'b1, 14'd16383, 16'd65532);
    in_data = {14'd4, 14'd3, 14'd2, 14'd1};
    in_valid = 1'b1;
    exp_q.push_back(16'd10);
    tick();
    drive(1'b0, 14'd0, 16'd0);
    check("ovf16_flag", {31'd0, acc_ovf16}, 32'd1);
    check("ovf16_acc", {16'd0, acc16}, SAT ? 32'd65535 : 32'd65528);
    check("acc24_131064", {8'd0, acc}, 32'd131064);
    drive(1'b0, 14'd0, 16'd0);
    drive(1'b0, 14'd0, 16'd0);
    check("ovf16_sticky", {31'd0, acc_ovf16}, 32'd1);
    check("ovf16_after10", {16'd0, acc16}, SAT ? 32'd65535 : 32'd2);
    check("acc24_131074", {8'd0, acc}, 32'd131074);
    check("acc24_no_ovf", {31'd0, acc_ovf}, 32'd0);
    acc_mode = 1'b0;
    acc_clr  = 1'b1;
    tick();
    acc_clr  = 1'b0;
    check("ovf16_cleared", {31'd0, acc_ovf16}, 32'd0);

    // reset with data in flight
    acc_mode = 1'b1;
    drive(1'b1, 14'd1111, 16'd4444);
    drive(1'b1, 14'd3333, 16'd13332);
    drive(1'b1, 14'd5555, 16'd22220);
    check("pre_rst_acc", {8'd0, acc}, 32'd4444);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sum", {16'd0, sum}, 32'd0);
    check("mid_rst_acc", {8'd0, acc}, 32'd0);
    check("mid_rst_acc_valid", {31'd0, acc_valid}, 32'd0);
    check("mid_rst_acc16", {16'd0, acc16}, 32'd0);
    exp_q.delete();
    vline = 2'b00; last_sum = 16'd0;
    m_acc24 = 0; m_acc16 = 0; m_ovf24 = 0; m_ovf16 = 0; m_v24 = 0; m_v16 = 0;
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
